// File: rtl/irq_pend_enc.sv
// Pending-request capture and single-source priority offer on a valid/ready handshake.
// Optional build macro IRQ_PEND_ENC_MASK_EN adds the per-source enable input `mask`.
module irq_pend_enc #(
  parameter int CNT_W = 8,
  parameter int EDGE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       req,
  input  logic             rdy,
  input  logic             ovf_clr,
`ifdef IRQ_PEND_ENC_MASK_EN
  input  logic [7:0]       mask,
`endif
  output logic             vld,
  output logic [2:0]       idx,
  output logic [7:0]       pend,
  output logic [7:0]       ovf,
  output logic [CNT_W-1:0] svc_cnt
);

  typedef enum logic {S_IDLE = 1'b0, S_OFFER = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [7:0]       req_q, req_d;
  logic [7:0]       pend_q, pend_d;
  logic [7:0]       ovf_q, ovf_d;
  logic [2:0]       idx_q, idx_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       set_s, clr_s, en_s, sel_s;
  logic             accept_s;

  // Highest set bit wins; an all-zero vector encodes to 0 and is never offered.
  function automatic logic [2:0] prio_enc(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      r = v[i] ? 3'(i) : r;
    end
    return r;
  endfunction

`ifdef IRQ_PEND_ENC_MASK_EN
  assign en_s = mask;
`else
  assign en_s = 8'hFF;
`endif

  assign sel_s = pend_q & en_s;

  always_comb begin
    accept_s = vld_q & rdy;
    clr_s    = accept_s ? (8'd1 << idx_q) : 8'd0;
    req_d    = req;
    if (EDGE != 0) begin
      set_s = req & ~req_q;
      // A fresh edge on a still-pending, not-being-cleared source is a lost request.
      ovf_d = (ovf_q & {8{~ovf_clr}}) | (set_s & pend_q & ~clr_s);
    end else begin
      set_s = req;
      ovf_d = 8'h00;
    end
    pend_d = (pend_q & ~clr_s) | set_s;
    if (accept_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    state_d = state_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (|sel_s) begin
          idx_d   = prio_enc(sel_s);
          vld_d   = 1'b1;
          state_d = S_OFFER;
        end else begin
          vld_d   = 1'b0;
        end
      end
      S_OFFER: begin
        if (accept_s) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          vld_d   = 1'b1;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= 8'h00;
      pend_q  <= 8'h00;
      ovf_q   <= 8'h00;
      idx_q   <= 3'd0;
      vld_q   <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign vld     = vld_q;
  assign idx     = idx_q;
  assign pend    = pend_q;
  assign ovf     = ovf_q;
  assign svc_cnt = cnt_q;

endmodule

// File: tb/tb_irq_pend_enc.sv
// Bench for irq_pend_enc: edge-mode (8- and 2-bit counters) and level-mode instances vs. a per-source model.
module tb_irq_pend_enc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rdy, ovf_clr;
  logic [7:0] req, mask;

  logic       vld_a, vld_b, vld_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic [7:0] pend_a, pend_b, pend_c;
  logic [7:0] ovf_a, ovf_b, ovf_c;
  logic [7:0] cnt_a, cnt_c;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;

  irq_pend_enc #(.CNT_W(8), .EDGE(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rdy(rdy), .ovf_clr(ovf_clr),
`ifdef IRQ_PEND_ENC_MASK_EN
    .mask(mask),
`endif
    .vld(vld_a), .idx(idx_a), .pend(pend_a), .ovf(ovf_a), .svc_cnt(cnt_a));

  irq_pend_enc #(.CNT_W(2), .EDGE(1)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .req(req), .rdy(rdy), .ovf_clr(ovf_clr),
`ifdef IRQ_PEND_ENC_MASK_EN
    .mask(mask),
`endif
    .vld(vld_b), .idx(idx_b), .pend(pend_b), .ovf(ovf_b), .svc_cnt(cnt_b));

  irq_pend_enc #(.CNT_W(8), .EDGE(0)) dut_lvl (
    .clk(clk), .rst_n(rst_n), .req(req), .rdy(rdy), .ovf_clr(ovf_clr),
`ifdef IRQ_PEND_ENC_MASK_EN
    .mask(mask),
`endif
    .vld(vld_c), .idx(idx_c), .pend(pend_c), .ovf(ovf_c), .svc_cnt(cnt_c));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state, index 0 = edge capture, index 1 = level capture.
  bit m_pend [2][8];
  bit m_ovf  [2][8];
  bit m_prev [2][8];
  bit m_vld  [2];
  int m_idx  [2];
  int m_cnt  [2];

  task automatic model_step(input int e);
    bit old_pend [8];
    bit acc, s, c;
    int best;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_pend[e][i] = 1'b0; m_ovf[e][i] = 1'b0; m_prev[e][i] = 1'b0;
      end
      m_vld[e] = 1'b0; m_idx[e] = 0; m_cnt[e] = 0;
      return;
    end
    acc = m_vld[e] && rdy;
    for (int i = 0; i < 8; i++) old_pend[i] = m_pend[e][i];
    for (int i = 0; i < 8; i++) begin
      s = (e == 0) ? (req[i] && !m_prev[e][i]) : req[i];
      c = acc && (m_idx[e] == i);
      if (e == 0 && s && old_pend[i] && !c) m_ovf[e][i] = 1'b1;
      else if (ovf_clr) m_ovf[e][i] = 1'b0;
      if (s) m_pend[e][i] = 1'b1;
      else if (c) m_pend[e][i] = 1'b0;
      m_prev[e][i] = req[i];
    end
    if (m_vld[e]) begin
      if (acc) begin
        m_vld[e] = 1'b0;
        m_cnt[e] = m_cnt[e] + 1;
      end
    end else begin
      best = -1;
      for (int i = 7; i >= 0; i--)
        if (best < 0 && old_pend[i] && mask[i]) best = i;
      if (best >= 0) begin
        m_vld[e] = 1'b1;
        m_idx[e] = best;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // Every falling edge: all three instances against the model.
  always @(negedge clk) begin
    logic [7:0] ep0, eo0, ep1, eo1;
    for (int i = 0; i < 8; i++) begin
      ep0[i] = m_pend[0][i]; eo0[i] = m_ovf[0][i];
      ep1[i] = m_pend[1][i]; eo1[i] = m_ovf[1][i];
    end
    chk("edge.vld",  32'(vld_a),  32'(m_vld[0]));
    chk("edge.idx",  32'(idx_a),  32'(m_idx[0]));
    chk("edge.pend", 32'(pend_a), 32'(ep0));
    chk("edge.ovf",  32'(ovf_a),  32'(eo0));
    chk("edge.cnt",  32'(cnt_a),  32'((m_cnt[0] > 255) ? 255 : m_cnt[0]));
    chk("c2.vld",    32'(vld_b),  32'(m_vld[0]));
    chk("c2.idx",    32'(idx_b),  32'(m_idx[0]));
    chk("c2.cnt",    32'(cnt_b),  32'((m_cnt[0] > 3) ? 3 : m_cnt[0]));
    chk("lvl.vld",   32'(vld_c),  32'(m_vld[1]));
    chk("lvl.idx",   32'(idx_c),  32'(m_idx[1]));
    chk("lvl.pend",  32'(pend_c), 32'(ep1));
    chk("lvl.ovf",   32'(ovf_c),  32'(eo1));
    chk("lvl.cnt",   32'(cnt_c),  32'((m_cnt[1] > 255) ? 255 : m_cnt[1]));
  end

  task automatic cyc(input logic [7:0] r, input logic y);
    req = r;
    rdy = y;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ovf_clr = 1'b0; mask = 8'hFF; req = 8'h00; rdy = 1'b0;
    cyc(8'h00, 1'b0);
    cyc(8'h00, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(8'h00, 1'b0);
      chk("idle.state", {vld_a, idx_a, pend_a, ovf_a, cnt_a}, 32'h0);
    end

    // Two sources, drained highest first with a bubble between offers.
    cyc(8'h12, 1'b1); chk("d.pend12", 32'(pend_a), 32'h12); chk("d.vld0", 32'(vld_a), 32'h0);
    cyc(8'h12, 1'b1); chk("d.vld1", 32'(vld_a), 32'h1); chk("d.idx4", 32'(idx_a), 32'h4);
    cyc(8'h12, 1'b1); chk("d.bubble", 32'(vld_a), 32'h0); chk("d.pend02", 32'(pend_a), 32'h02);
    cyc(8'h12, 1'b1); chk("d.idx1", 32'(idx_a), 32'h1); chk("d.vld1b", 32'(vld_a), 32'h1);
    cyc(8'h12, 1'b1); chk("d.pend0", 32'(pend_a), 32'h0); chk("d.cnt2", 32'(cnt_a), 32'h2);

    // No preemption while held.
    cyc(8'h00, 1'b0);
    cyc(8'h02, 1'b0);
    cyc(8'h02, 1'b0);
    cyc(8'h82, 1'b0); chk("np.idx1", 32'(idx_a), 32'h1); chk("np.pend82", 32'(pend_a), 32'h82);
    cyc(8'h82, 1'b0); chk("np.hold", 32'({vld_a, idx_a}), 32'({1'b1, 3'd1}));
    cyc(8'h82, 1'b1); chk("np.acc", 32'(pend_a), 32'h80);
    cyc(8'h82, 1'b1); chk("np.idx7", 32'({vld_a, idx_a}), 32'({1'b1, 3'd7}));
    cyc(8'h82, 1'b1); chk("np.cnt4", 32'(cnt_a), 32'h4);

    // Overflow, clear, and set-wins-over-clear.
    cyc(8'h00, 1'b0);
    cyc(8'h88, 1'b0);
    cyc(8'h88, 1'b0);
    cyc(8'h80, 1'b0);
    cyc(8'h88, 1'b0); chk("ov.ovf08", 32'(ovf_a), 32'h08);
    ovf_clr = 1'b1;
    cyc(8'h88, 1'b0); chk("ov.clr", 32'(ovf_a), 32'h00);
    ovf_clr = 1'b0;
    cyc(8'h80, 1'b1); chk("ov.pend08", 32'(pend_a), 32'h08);
    cyc(8'h80, 1'b0); chk("ov.idx3", 32'({vld_a, idx_a}), 32'({1'b1, 3'd3}));
    cyc(8'h88, 1'b1); chk("sw.pend", 32'(pend_a), 32'h08); chk("sw.ovf", 32'(ovf_a), 32'h00);
    chk("sw.cnt6", 32'(cnt_a), 32'h6);
    cyc(8'h88, 1'b1);
    cyc(8'h88, 1'b1); chk("sw.pend0", 32'(pend_a), 32'h00); chk("sw.cnt7", 32'(cnt_a), 32'h7);

    // Reset mid-offer, then a held request captured after release.
    cyc(8'h00, 1'b0);
    cyc(8'h01, 1'b0);
    cyc(8'h01, 1'b0); chk("rm.vld", 32'(vld_a), 32'h1);
    rst_n = 1'b0;
    cyc(8'h01, 1'b0); chk("rm.zero", {vld_a, idx_a, pend_a, ovf_a, cnt_a}, 32'h0);
    rst_n = 1'b1;
    cyc(8'h01, 1'b0); chk("rm.capt", 32'(pend_a), 32'h01);

    // Enough accepts to saturate both counter widths.
    for (int i = 0; i < 700; i++) cyc((i % 2 == 1) ? 8'h01 : 8'h00, 1'b1);
    chk("sat.cnt8", 32'(cnt_a), 32'hFF);
    chk("sat.cnt2", 32'(cnt_b), 32'h3);

`ifdef IRQ_PEND_ENC_MASK_EN
    rst_n = 1'b0;
    cyc(8'h00, 1'b0);
    rst_n = 1'b1;
    cyc(8'h00, 1'b0);
    mask = 8'h7F;
    cyc(8'h81, 1'b0); chk("mk.pend81", 32'(pend_a), 32'h81);
    cyc(8'h81, 1'b0); chk("mk.idx0", 32'({vld_a, idx_a}), 32'({1'b1, 3'd0}));
    cyc(8'h81, 1'b1); chk("mk.pend80", 32'(pend_a), 32'h80);
    mask = 8'hFF;
    cyc(8'h81, 1'b0); chk("mk.idx7", 32'({vld_a, idx_a}), 32'({1'b1, 3'd7}));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
